// File: rtl/ex_muldiv_scheduler_pkg.sv
// Shared types and helpers for the execute-stage M-extension scheduler.
// Build option MDU_DIV_EARLY_OUT_EN is consumed by ex_muldiv_scheduler.sv.
package common;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL_ST = 2'd1,
    MD_DIV_ST = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  localparam int DIV_ITERS = 32;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_scheduler_div_iter.sv
// Restoring divider on unsigned magnitudes, one quotient bit per cycle.
// quotient_o/remainder_o present the final values in the cycle done_o is high.
module mdu_div_iter
  import common::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  logic [XLEN-1:0] rem_q, quo_q, dsr_q;
  logic [5:0]      cnt_q;
  logic            active_q;
  logic [XLEN:0]   shifted_s, diff_s;
  logic [XLEN-1:0] rem_d, quo_d;

  // One restoring step: shift in the next dividend bit, keep the subtraction if it did not borrow.
  always_comb begin
    shifted_s = {rem_q, quo_q[XLEN-1]};
    diff_s    = shifted_s - {1'b0, dsr_q};
    if (diff_s[XLEN]) begin
      rem_d = shifted_s[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_d = diff_s[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  assign done_o      = active_q && (cnt_q == 6'(DIV_ITERS - 1));
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

  // Iteration registers and step counter.
  always_ff @(posedge clk) begin
    if (rst_n || clear_i) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= 6'd0;
      active_q <= 1'b0;
    end else if (start_i) begin
      rem_q    <= '0;
      quo_q    <= dividend_i;
      dsr_q    <= divisor_i;
      cnt_q    <= 6'd0;
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_q + 6'd1;
      active_q <= !done_o;
    end else begin
      active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_muldiv_scheduler.sv
// Execute-stage sequencer for multi-cycle MUL/DIV/REM with EX stall and one-cycle result strobe.
// Optional MDU_DIV_EARLY_OUT_EN: skip the divider when |rs1| < |rs2|.
module ex_muldiv_scheduler
  import common::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            md_req,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic            stall_ex_out,
  output logic            md_busy,
  output logic [XLEN-1:0] md_result,
  output logic            md_result_valid
);

  md_state_e state_q;
  md_op_e    op_s, op_q;
  logic [32:0] mul_a_q, mul_b_q;
  logic [7:0]  mul_cnt_q;
  logic        q_neg_q, r_neg_q, valid_q;
  logic [XLEN-1:0] result_q;

  logic        is_mul_s, is_rem_s, is_sgn_s, special_s, accept_s, div_start_s, div_done_s;
  logic [XLEN-1:0] mag1_s, mag2_s, special_res_s, div_quo_s, div_rem_s, mul_res_s;
  logic signed [65:0] prod_s;
  logic unused_prod_s;

  assign op_s     = md_op_e'(md_op);
  assign is_mul_s = ~md_op[2];
  assign is_rem_s = md_op[1];
  assign is_sgn_s = ~md_op[0];
  assign mag1_s   = mag32(data1, is_sgn_s);
  assign mag2_s   = mag32(data2, is_sgn_s);

  // Divides resolved without iterating: divide by zero, signed overflow, optional early-out.
  always_comb begin
    special_s     = 1'b0;
    special_res_s = 32'h0000_0000;
    if (data2 == 32'h0000_0000) begin
      special_s     = 1'b1;
      special_res_s = is_rem_s ? data1 : 32'hFFFF_FFFF;
    end else if (is_sgn_s && (data1 == 32'h8000_0000) && (data2 == 32'hFFFF_FFFF)) begin
      special_s     = 1'b1;
      special_res_s = is_rem_s ? 32'h0000_0000 : 32'h8000_0000;
    end
`ifdef MDU_DIV_EARLY_OUT_EN
    else if (mag1_s < mag2_s) begin
      special_s     = 1'b1;
      special_res_s = is_rem_s ? data1 : 32'h0000_0000;
    end
`endif
    else begin
      special_s     = 1'b0;
      special_res_s = 32'h0000_0000;
    end
  end

  assign accept_s    = (state_q == MD_IDLE) && md_req && !flush;
  assign div_start_s = accept_s && !is_mul_s && !special_s;

  assign prod_s        = $signed(mul_a_q) * $signed(mul_b_q);
  assign mul_res_s     = (op_q == MD_MUL) ? prod_s[31:0] : prod_s[63:32];
  assign unused_prod_s = ^prod_s[65:64];

  mdu_div_iter #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (flush),
    .start_i     (div_start_s),
    .dividend_i  (mag1_s),
    .divisor_i   (mag2_s),
    .done_o      (div_done_s),
    .quotient_o  (div_quo_s),
    .remainder_o (div_rem_s)
  );

  // Stall is combinational so the request cycle itself holds EX; forced low while reset is asserted.
  assign stall_ex_out    = ~rst_n & (((state_q == MD_IDLE) & md_req) |
                                     (state_q == MD_MUL_ST) | (state_q == MD_DIV_ST));
  assign md_busy         = (state_q != MD_IDLE);
  assign md_result       = result_q;
  assign md_result_valid = valid_q;

  // Scheduler FSM; result and strobe are registered on the transition into DONE.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= MD_IDLE;
      op_q      <= MD_MUL;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_cnt_q <= 8'd0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (accept_s) begin
            op_q      <= op_s;
            q_neg_q   <= is_sgn_s & (data1[31] ^ data2[31]);
            r_neg_q   <= is_sgn_s & data1[31];
            mul_a_q   <= {~(md_op[1] & md_op[0]) & data1[31], data1};
            mul_b_q   <= {~md_op[1] & data2[31], data2};
            mul_cnt_q <= 8'd0;
            if (is_mul_s) begin
              state_q <= MD_MUL_ST;
            end else if (special_s) begin
              result_q <= special_res_s;
              valid_q  <= 1'b1;
              state_q  <= MD_DONE;
            end else begin
              state_q <= MD_DIV_ST;
            end
          end else begin
            state_q <= MD_IDLE;
          end
        end
        MD_MUL_ST: begin
          if (flush) begin
            state_q <= MD_IDLE;
          end else if (mul_cnt_q == 8'(MUL_LATENCY - 1)) begin
            result_q <= mul_res_s;
            valid_q  <= 1'b1;
            state_q  <= MD_DONE;
          end else begin
            mul_cnt_q <= mul_cnt_q + 8'd1;
          end
        end
        MD_DIV_ST: begin
          if (flush) begin
            state_q <= MD_IDLE;
          end else if (div_done_s) begin
            result_q <= op_q[1] ? neg_if(div_rem_s, r_neg_q) : neg_if(div_quo_s, q_neg_q);
            valid_q  <= 1'b1;
            state_q  <= MD_DONE;
          end else begin
            state_q <= MD_DIV_ST;
          end
        end
        MD_DONE: begin
          // A request still high here is the completing instruction; never re-accept it.
          state_q <= MD_IDLE;
        end
        default: begin
          state_q <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_scheduler.sv
// Directed + random scoreboard bench for ex_muldiv_scheduler (MUL_LATENCY = 2).
module tb_ex_muldiv_scheduler;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;
  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;
`ifdef MDU_DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = DIV_LAT;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, md_req;
  logic [2:0]  md_op;
  logic [31:0] data1, data2;
  logic        stall_ex_out, md_busy, md_result_valid;
  logic [31:0] md_result;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fails  = 0;
  bit nostrobe;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;

  ex_muldiv_scheduler #(.XLEN(32), .MUL_LATENCY(MUL_LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .md_req          (md_req),
    .md_op           (md_op),
    .data1           (data1),
    .data2           (data2),
    .stall_ex_out    (stall_ex_out),
    .md_busy         (md_busy),
    .md_result       (md_result),
    .md_result_valid (md_result_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    logic signed [31:0] ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    ia = a;
    ib = b;
    p  = 64'd0;
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * zb; return p[63:32]; end
      OP_MULHU:  begin p = za * zb; return p[63:32]; end
      OP_DIV:    return (b == 32'd0) ? 32'hFFFF_FFFF :
                        (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(ia / ib);
      OP_REM:    return (b == 32'd0) ? a :
                        (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib);
      OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default:   return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (!op[0] && a[31]) ? -a : a;
    mb = (!op[0] && b[31]) ? -b : b;
    if (!op[2]) return 1 + MUL_LAT;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (ma < mb) return EO_LAT;
    return DIV_LAT;
  endfunction

  // Entered and left just after a rising edge; the request is held until the strobe, like a stalled EX stage.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    exp_t e;
    int   cyc;
    bit   seen, stall_ok;
    logic [31:0] got;
    e.res = exp_res;
    e.lat = exp_lat;
    sb_q.push_back(e);
    md_req = 1'b1; md_op = op; data1 = a; data2 = b;
    cyc = 0; seen = 1'b0; stall_ok = 1'b1; got = 32'd0;
    @(negedge clk);
    while (!seen && cyc <= 40) begin
      if (md_result_valid === 1'b1) begin
        seen = 1'b1;
        got  = md_result;
        if (stall_ex_out !== 1'b0) stall_ok = 1'b0;
      end else begin
        if (stall_ex_out !== 1'b1) stall_ok = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    e = sb_q.pop_front();
    check({tag, " strobe"}, {31'd0, seen}, 32'd1);
    check({tag, " result"}, got, e.res);
    check({tag, " latency"}, 32'(cyc), 32'(e.lat));
    check({tag, " stall"}, {31'd0, stall_ok}, 32'd1);
    @(posedge clk); #1;
    md_req = 1'b0;
    check({tag, " idle_after"}, {30'd0, md_busy, md_result_valid}, 32'd0);
    check({tag, " hold"}, md_result, e.res);
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; md_req = 1'b1; md_op = OP_DIV;
    data1 = 32'd50; data2 = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst result", md_result, 32'd0);
    check("rst valid", {31'd0, md_result_valid}, 32'd0);
    check("rst busy", {31'd0, md_busy}, 32'd0);
    check("rst stall", {31'd0, stall_ex_out}, 32'd0);
    rst_n = 1'b0; md_req = 1'b0;
    @(posedge clk); #1;

    run_op("mul",     OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1 + MUL_LAT);
    run_op("mulhu",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1 + MUL_LAT);
    run_op("mulhsu",  OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1 + MUL_LAT);
    run_op("mulh",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1 + MUL_LAT);
    run_op("div",     OP_DIV,    32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFA, DIV_LAT);
    run_op("rem",     OP_REM,    32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE, DIV_LAT);
    run_op("divu",    OP_DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT);
    run_op("remu",    OP_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT);
    run_op("div0",    OP_DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    run_op("rem0",    OP_REM,    32'd5,        32'd0,        32'd5,        1);
    run_op("divovf",  OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf",  OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       1);
    run_op("divumax", OP_DIVU,   32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, DIV_LAT);
    run_op("divu_hi", OP_DIVU,   32'h8000_0000, 32'd2,        32'h4000_0000, DIV_LAT);
    run_op("div_eo",  OP_DIV,    32'd3,        32'd9,        32'd0,        EO_LAT);
    run_op("rem_eo",  OP_REM,    32'd3,        32'd9,        32'd3,        EO_LAT);

    // Flush a divide at T+10, issue a multiply at T+11.
    md_req = 1'b1; md_op = OP_DIV; data1 = 32'hFFFF_FFEC; data2 = 32'd3;
    @(posedge clk); #1;
    md_req = 1'b0;
    nostrobe = 1'b1;
    repeat (9) begin
      if (md_result_valid !== 1'b0) nostrobe = 1'b0;
      @(posedge clk); #1;
    end
    check("flush busy_before", {31'd0, md_busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (md_result_valid !== 1'b0) nostrobe = 1'b0;
    check("flush idle", {31'd0, md_busy}, 32'd0);
    check("flush nostrobe", {31'd0, nostrobe}, 32'd1);
    run_op("flush_mul", OP_MUL, 32'd6, 32'd7, 32'd42, 1 + MUL_LAT);
    nostrobe = 1'b1;
    repeat (DIV_LAT) begin
      if (md_result_valid !== 1'b0) nostrobe = 1'b0;
      @(posedge clk); #1;
    end
    check("flush late_strobe", {31'd0, nostrobe}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = (i % 4 == 0) ? 32'd0 : ((i % 4 == 1) ? 32'($urandom_range(1, 300)) : $urandom);
      run_op("rand", r_op, r_a, r_b, ref_md(r_op, r_a, r_b), ref_lat(r_op, r_a, r_b));
    end

    // Reset in the middle of a divide.
    run_op("pre_rst", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1 + MUL_LAT);
    md_req = 1'b1; md_op = OP_DIVU; data1 = 32'd1000; data2 = 32'd3;
    @(posedge clk); #1;
    md_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b1; md_req = 1'b1;
    @(posedge clk); #1;
    check("midrst result", md_result, 32'd0);
    check("midrst valid", {31'd0, md_result_valid}, 32'd0);
    check("midrst busy", {31'd0, md_busy}, 32'd0);
    check("midrst stall", {31'd0, stall_ex_out}, 32'd0);
    rst_n = 1'b0; md_req = 1'b0;
    @(posedge clk); #1;
    run_op("post_rst", OP_DIVU, 32'd1000, 32'd3, 32'd333, DIV_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
